// File: rtl/shift_subtract_divider_pkg.sv
// Shared FSM encodings and default width for the divider and multiplier control.
// Optional build macro used by the divider: SIGNED_DIV_EN.
package shift_subtract_divider_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/shift_subtract_divider_restoring_subtractor.sv
// Trial subtraction for one restoring-division step.
// Build macro SIGNED_DIV_EN does not affect this block.
module restoring_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic [WIDTH:0]   diff,
    output logic             borrow
);

    // The shifted partial remainder is below 2*M, so a WIDTH+1 minuend never loses a bit.
    assign diff   = minuend - {1'b0, subtrahend};
    assign borrow = diff[WIDTH];

endmodule

// File: rtl/shift_subtract_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands with truncation toward zero.
module shift_subtract_divider
    import shift_subtract_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t         state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] q_nxt;

    logic [WIDTH-1:0] dvd_in;
    logic [WIDTH-1:0] dvs_in;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] dz_rem;

    assign a_sh  = {a, q[WIDTH-1]};
    assign a_nxt = borrow ? a_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_nxt = {q[WIDTH-2:0], ~borrow};

    restoring_subtractor #(
        .WIDTH(WIDTH)
    ) u_sub (
        .minuend   (a_sh),
        .subtrahend(m),
        .diff      (diff),
        .borrow    (borrow)
    );

`ifdef SIGNED_DIV_EN
    logic neg_q;
    logic neg_r;

    // Divide on magnitudes; signs are re-applied as results are registered.
    assign dvd_in = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_in = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign q_fix  = neg_q ? -q_nxt : q_nxt;
    assign r_fix  = neg_r ? -a_nxt : a_nxt;
    assign dz_rem = neg_r ? -q : q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign dvd_in = dividend;
    assign dvs_in = divisor;
    assign q_fix  = q_nxt;
    assign r_fix  = a_nxt;
    assign dz_rem = q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            a           <= '0;
            q           <= '0;
            m           <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m           <= dvs_in;
                        q           <= dvd_in;
                        a           <= '0;
                        count       <= CW'(WIDTH);
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        state       <= (divisor == '0) ? DONE : DIVIDE;
                    end
                end
                DIVIDE: begin
                    a     <= a_nxt;
                    q     <= q_nxt;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    // A zero divisor skips DIVIDE and reports from here instead.
                    if (m == '0) begin
                        quotient    <= '1;
                        remainder   <= dz_rem;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                    end else begin
                        done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
